// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: bundles the run controls and all timing outputs of vga_timing_gen.
//
// Modports:
//   master - the timing generator: takes en/swap_req, drives counters, syncs, strobes, ack.
//   slave  - the consumer (framebuffer pipeline / DAC / CPU): drives en/swap_req.
//
// Signals:
//   en          run enable; 0 freezes the counters
//   swap_req    level request for a buffer swap at the next vertical blank
//   hs, vs      horizontal pixel / vertical line counters (undelayed)
//   vga_hsync   horizontal sync pin, delayed
//   vga_vsync   vertical sync pin, delayed
//   sync_b      composite sync (vga_hsync & vga_vsync)
//   sync_blank  1 outside the active area, delayed
//   de          data enable (~sync_blank)
//   line_start  1-clock pulse at hs == 0
//   frame_start 1-clock pulse at hs == 0, vs == 0
//   swap_ack    1-clock swap acknowledge
//   frame_cnt   frame counter   (only with VGA_TIMING_FRAME_CNT_EN defined)
//   frame_odd   frame_cnt[0]    (only with VGA_TIMING_FRAME_CNT_EN defined)

interface vga_timing_gen_if #(
    parameter int unsigned CNT_W = 10
);
    logic             en;
    logic             swap_req;
    logic [CNT_W-1:0] hs;
    logic [CNT_W-1:0] vs;
    logic             vga_hsync;
    logic             vga_vsync;
    logic             sync_b;
    logic             sync_blank;
    logic             de;
    logic             line_start;
    logic             frame_start;
    logic             swap_ack;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
    logic             frame_odd;
`endif

    modport master (
        input  en,
        input  swap_req,
`ifdef VGA_TIMING_FRAME_CNT_EN
        output frame_cnt,
        output frame_odd,
`endif
        output hs,
        output vs,
        output vga_hsync,
        output vga_vsync,
        output sync_b,
        output sync_blank,
        output de,
        output line_start,
        output frame_start,
        output swap_ack
    );

    modport slave (
        output en,
        output swap_req,
`ifdef VGA_TIMING_FRAME_CNT_EN
        input  frame_cnt,
        input  frame_odd,
`endif
        input  hs,
        input  vs,
        input  vga_hsync,
        input  vga_vsync,
        input  sync_b,
        input  sync_blank,
        input  de,
        input  line_start,
        input  frame_start,
        input  swap_ack
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator for the video output path.
//
// Counts pixels (hs) and lines (vs), decodes sync / blank regions, optionally delays the
// decoded outputs through PIPE_DLY flops to line up with a pixel pipeline, emits line and
// frame strobes, and acknowledges framebuffer swap requests at the start of vertical blank.
//
// Ports:
//   clk_25  pixel clock
//   rst     synchronous, active-high reset
//   bus     vga_timing_gen_if.master (en, swap_req in; counters, syncs, strobes, ack out)
//
// Optional feature (macro VGA_TIMING_FRAME_CNT_EN):
//   defined   - adds bus.frame_cnt (16-bit frame counter, wraps) and bus.frame_odd
//   undefined - no frame counter logic

module vga_timing_gen #(
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIPE_DLY = 0
) (
    input  logic           clk_25,
    input  logic           rst,
    vga_timing_gen_if.master bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT        = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT        = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Decode word carried through the delay pipe: {hsync asserted, vsync asserted, blank}.
    // Polarity is applied only at the pins so the pipe holds one encoding.
    localparam logic [2:0] RAW_IDLE = 3'b001;

    logic en;
    logic swap_req;
    assign en       = bus.en;
    assign swap_req = bus.swap_req;

    // ------------------------------------------------------------------
    // Pixel / line counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] hs_q, hs_d;
    logic [CNT_W-1:0] vs_q, vs_d;
    logic             h_wrap;
    logic             v_wrap;

    assign h_wrap = (hs_q == H_LAST);
    assign v_wrap = (vs_q == V_LAST);

    always_comb begin
        hs_d = hs_q;
        vs_d = vs_q;
        if (en) begin
            if (h_wrap) begin
                hs_d = '0;
                vs_d = v_wrap ? '0 : vs_q + CNT_W'(1);
            end else begin
                hs_d = hs_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            hs_q <= '0;
            vs_q <= '0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    // ------------------------------------------------------------------
    // Raw region decode from the current counters
    // ------------------------------------------------------------------
    logic       h_sync_raw;
    logic       v_sync_raw;
    logic       active_raw;
    logic [2:0] raw;

    assign h_sync_raw = (hs_q >= H_SYNC_START) && (hs_q < H_SYNC_END);
    assign v_sync_raw = (vs_q >= V_SYNC_START) && (vs_q < V_SYNC_END);
    assign active_raw = (hs_q < H_ACT) && (vs_q < V_ACT);
    assign raw        = {h_sync_raw, v_sync_raw, ~active_raw};

    // ------------------------------------------------------------------
    // Output delay pipe. It shifts regardless of en so a frozen raster keeps presenting
    // the frozen decode once the pipe drains.
    // ------------------------------------------------------------------
    logic [2:0] dly;

    if (PIPE_DLY == 0) begin : g_no_dly
        // Combinational path; hold the pins idle while reset is applied.
        assign dly = rst ? RAW_IDLE : raw;
    end else begin : g_dly
        logic [2:0] pipe_q [PIPE_DLY];

        always_ff @(posedge clk_25) begin
            if (rst) begin
                for (int i = 0; i < int'(PIPE_DLY); i++) begin
                    pipe_q[i] <= RAW_IDLE;
                end
            end else begin
                pipe_q[0] <= raw;
                for (int i = 1; i < int'(PIPE_DLY); i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign dly = pipe_q[PIPE_DLY-1];
    end

    logic hsync_pin;
    logic vsync_pin;

    assign hsync_pin = HS_POL ? dly[2] : ~dly[2];
    assign vsync_pin = VS_POL ? dly[1] : ~dly[1];

    // ------------------------------------------------------------------
    // Strobes. Gated by rst so a reset never produces a partial pulse.
    // ------------------------------------------------------------------
    logic line_start;
    logic frame_start;

    assign line_start  = en & ~rst & (hs_q == '0);
    assign frame_start = line_start & (vs_q == '0);

    // ------------------------------------------------------------------
    // Swap handshake: sampled on the first clock of vertical blank, acknowledged one
    // clock later. Only one edge cycle exists per frame, so at most one ack per frame.
    // ------------------------------------------------------------------
    logic vblank_edge;
    logic swap_ack_q;

    assign vblank_edge = en & (hs_q == '0) & (vs_q == V_ACT);

    always_ff @(posedge clk_25) begin
        if (rst) begin
            swap_ack_q <= 1'b0;
        end else begin
            swap_ack_q <= swap_req & vblank_edge;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // ------------------------------------------------------------------
    // Frame counter (wraps naturally at 16 bits)
    // ------------------------------------------------------------------
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk_25) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
        end else if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
    assign bus.frame_odd = frame_cnt_q[0];
`endif

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.vga_hsync   = hsync_pin;
    assign bus.vga_vsync   = vsync_pin;
    assign bus.sync_b      = hsync_pin & vsync_pin;
    assign bus.sync_blank  = dly[0];
    assign bus.de          = ~dly[0];
    assign bus.line_start  = line_start;
    assign bus.frame_start = frame_start;
    // A stalled raster must not report an ack.
    assign bus.swap_ack    = swap_ack_q & en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen.
// dut_sm: small raster (14 x 7, HS_POL=1, PIPE_DLY=3) checked every cycle against a model
//         built on a linear pixel position, plus directed scenarios.
// dut_df: default 640x480 timing, horizontal behaviour over the first three lines.

module tb_vga_timing_gen;

    localparam int HA  = 8;
    localparam int HF  = 2;
    localparam int HSW = 2;
    localparam int HB  = 2;
    localparam int VA  = 4;
    localparam int VF  = 1;
    localparam int VSW = 1;
    localparam int VB  = 1;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int FR  = HT * VT;
    localparam int DLY = 3;
    localparam logic [2:0] IDLE3 = 3'b001;  // {hsync asserted, vsync asserted, blank}

    logic clk_25 = 1'b0;
    always #5 clk_25 = ~clk_25;

    logic rst_s;
    logic rst_d;

    vga_timing_gen_if #(.CNT_W(10)) sm_if ();
    vga_timing_gen_if #(.CNT_W(10)) df_if ();

    vga_timing_gen #(
        .CNT_W   (10),
        .H_ACTIVE(HA),
        .H_FP    (HF),
        .H_SYNC  (HSW),
        .H_BP    (HB),
        .V_ACTIVE(VA),
        .V_FP    (VF),
        .V_SYNC  (VSW),
        .V_BP    (VB),
        .HS_POL  (1'b1),
        .VS_POL  (1'b0),
        .PIPE_DLY(DLY)
    ) dut_sm (
        .clk_25(clk_25),
        .rst   (rst_s),
        .bus   (sm_if)
    );

    vga_timing_gen dut_df (
        .clk_25(clk_25),
        .rst   (rst_d),
        .bus   (df_if)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait expired (t=%0t)", nm, $time);
    endtask

    // ------------------------------------------------------------------
    // Model of dut_sm: raster position as one linear index into the frame.
    // ------------------------------------------------------------------
    int         m_pos  = 0;
    int         m_fcnt = 0;
    bit         m_ack  = 1'b0;
    logic [2:0] m_hist [DLY];

    function automatic int hof(input int p);
        return p % HT;
    endfunction

    function automatic int vof(input int p);
        return p / HT;
    endfunction

    function automatic logic [2:0] decode(input int p);
        logic hs_a, vs_a, blank;
        hs_a  = (hof(p) >= HA + HF) && (hof(p) < HA + HF + HSW);
        vs_a  = (vof(p) >= VA + VF) && (vof(p) < VA + VF + VSW);
        blank = !((hof(p) < HA) && (vof(p) < VA));
        return {hs_a, vs_a, blank};
    endfunction

    always @(posedge clk_25) begin
        if (rst_s) begin
            m_pos  <= 0;
            m_ack  <= 1'b0;
            m_fcnt <= 0;
            for (int i = 0; i < DLY; i++) m_hist[i] <= IDLE3;
        end else begin
            m_ack <= sm_if.swap_req && sm_if.en && hof(m_pos) == 0 && vof(m_pos) == VA;
            if (sm_if.en && m_pos == 0) m_fcnt <= (m_fcnt + 1) % 65536;
            for (int i = 1; i < DLY; i++) m_hist[i] <= m_hist[i-1];
            m_hist[0] <= decode(m_pos);
            if (sm_if.en) m_pos <= (m_pos + 1) % FR;
        end
    end

    task automatic compare_sm();
        logic [2:0] o;
        logic       ls;
        o  = m_hist[DLY-1];
        ls = sm_if.en && !rst_s && hof(m_pos) == 0;
        chk("m_hs",          32'(sm_if.hs),          hof(m_pos));
        chk("m_vs",          32'(sm_if.vs),          vof(m_pos));
        chk("m_vga_hsync",   32'(sm_if.vga_hsync),   32'(o[2]));
        chk("m_vga_vsync",   32'(sm_if.vga_vsync),   32'(!o[1]));
        chk("m_sync_b",      32'(sm_if.sync_b),      32'(o[2] && !o[1]));
        chk("m_sync_blank",  32'(sm_if.sync_blank),  32'(o[0]));
        chk("m_de",          32'(sm_if.de),          32'(!o[0]));
        chk("m_line_start",  32'(sm_if.line_start),  32'(ls));
        chk("m_frame_start", 32'(sm_if.frame_start), 32'(ls && vof(m_pos) == 0));
        chk("m_swap_ack",    32'(sm_if.swap_ack),    32'(m_ack && sm_if.en));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("m_frame_cnt",   32'(sm_if.frame_cnt),   m_fcnt);
        chk("m_frame_odd",   32'(sm_if.frame_odd),   m_fcnt % 2);
`endif
    endtask

    always @(negedge clk_25) begin
        if (chk_on) compare_sm();
    end

    // Waits (at negedges) until dut_sm shows hs == h and, if v >= 0, vs == v.
    task automatic wait_sm(input int h, input int v, input int lim, input string nm);
        int n   = 0;
        bit hit = 1'b0;
        while (!hit && n < lim) begin
            @(negedge clk_25);
            n++;
            hit = (int'(sm_if.hs) == h) && (v < 0 || int'(sm_if.vs) == v);
        end
        if (!hit) timeout(nm);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios on dut_sm
    // ------------------------------------------------------------------
    task automatic run_small();
        int acks;
        int n;
        bit hit;

        // First clocks after reset release: strobes fire, pipe still idle for 3 clocks.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_25);
            chk("rel_hs", 32'(sm_if.hs), k);
            if (k == 0) begin
                chk("rel_line_start",  32'(sm_if.line_start),  1);
                chk("rel_frame_start", 32'(sm_if.frame_start), 1);
            end
            if (k < 3) begin
                chk("rel_blank",      32'(sm_if.sync_blank), 1);
                chk("rel_de",         32'(sm_if.de),         0);
                chk("rel_hsync_idle", 32'(sm_if.vga_hsync),  0);
                chk("rel_vsync_idle", 32'(sm_if.vga_vsync),  1);
            end else begin
                chk("rel_de_on", 32'(sm_if.de), 1);
            end
        end

`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("fcnt_early", 32'(sm_if.frame_cnt), 1);
        repeat (3 * FR - 3) @(negedge clk_25);
        chk("fcnt_3frames", 32'(sm_if.frame_cnt), 3);
        chk("frame_odd_3",  32'(sm_if.frame_odd), 1);
`endif

        // Delayed hsync: high for 2 clocks starting 3 clocks after hs == 10.
        wait_sm(10, -1, 2 * HT, "hsync_wait");
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk_25);
            chk("hsync_align", 32'(sm_if.vga_hsync), 32'(k == 3 || k == 4));
        end

        // Enable dropped with hs=5, vs=2 for 7 clocks.
        wait_sm(4, 2, 2 * FR, "en_wait");
        @(posedge clk_25);
        #1 sm_if.en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_25);
            chk("en_hold_hs", 32'(sm_if.hs),         5);
            chk("en_hold_vs", 32'(sm_if.vs),         2);
            chk("en_no_ls",   32'(sm_if.line_start), 0);
            @(posedge clk_25);
        end
        #1 sm_if.en = 1'b1;
        @(negedge clk_25);
        chk("en_resume_hold", 32'(sm_if.hs), 5);
        @(negedge clk_25);
        chk("en_resume_hs", 32'(sm_if.hs), 6);
        chk("en_resume_vs", 32'(sm_if.vs), 2);

        // Swap request raised at vs=1, held until ack.
        wait_sm(0, 1, 2 * FR, "swap_wait");
        @(posedge clk_25);
        #1 sm_if.swap_req = 1'b1;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 2 * FR) begin
            @(negedge clk_25);
            n++;
            hit = sm_if.swap_ack;
        end
        if (!hit) begin
            timeout("swap_ack_wait");
        end else begin
            chk("ack_hs", 32'(sm_if.hs), 1);
            chk("ack_vs", 32'(sm_if.vs), VA);
        end
        @(posedge clk_25);
        #1 sm_if.swap_req = 1'b0;
        acks = 0;
        repeat (FR) begin
            @(negedge clk_25);
            if (sm_if.swap_ack) acks++;
        end
        chk("ack_after_drop", acks, 0);

        // Request held through two whole frames: one ack per frame.
        wait_sm(0, 1, 2 * FR, "swap2_wait");
        @(posedge clk_25);
        #1 sm_if.swap_req = 1'b1;
        acks = 0;
        repeat (2 * FR) begin
            @(negedge clk_25);
            if (sm_if.swap_ack) acks++;
        end
        chk("ack_two_frames", acks, 2);
        @(posedge clk_25);
        #1 sm_if.swap_req = 1'b0;

        // Reset mid-frame at hs=9, vs=3.
        wait_sm(8, 3, 2 * FR, "rst_wait");
        @(posedge clk_25);
        #1 rst_s = 1'b1;
        chk("pre_rst_hs", 32'(sm_if.hs), 9);
        @(posedge clk_25);
        #1;
        chk("rst_hs",       32'(sm_if.hs),         0);
        chk("rst_vs",       32'(sm_if.vs),         0);
        chk("rst_blank",    32'(sm_if.sync_blank), 1);
        chk("rst_swap_ack", 32'(sm_if.swap_ack),   0);
        chk("rst_no_ls",    32'(sm_if.line_start), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("rst_fcnt", 32'(sm_if.frame_cnt), 0);
`endif
        @(posedge clk_25);
        #1 rst_s = 1'b0;
        repeat (FR + 4) @(negedge clk_25);
    endtask

    // ------------------------------------------------------------------
    // Default timing: first three lines
    // ------------------------------------------------------------------
    task automatic run_default();
        int max_h    = 0;
        int lo_first = -1;
        int lo_last  = -1;
        int lo_cnt   = 0;
        int vlo      = 0;
        int de_cnt   = 0;
        int de_bad   = 0;
        int sb_bad   = 0;
        int ls_cnt   = 0;
        int fs_cnt   = 0;
        int seq_bad  = 0;
        for (int k = 0; k < 3 * 800; k++) begin
            @(negedge clk_25);
            if (int'(df_if.hs) > max_h) max_h = int'(df_if.hs);
            if (int'(df_if.hs) != k % 800 || int'(df_if.vs) != k / 800) seq_bad++;
            if (!df_if.vga_hsync) begin
                lo_cnt++;
                if (k < 800) begin
                    if (lo_first < 0) lo_first = int'(df_if.hs);
                    lo_last = int'(df_if.hs);
                end
            end
            if (!df_if.vga_vsync) vlo++;
            if (df_if.de) de_cnt++;
            if (df_if.de === df_if.sync_blank) de_bad++;
            if (df_if.sync_b !== (df_if.vga_hsync & df_if.vga_vsync)) sb_bad++;
            if (df_if.line_start) ls_cnt++;
            if (df_if.frame_start) fs_cnt++;
        end
        @(negedge clk_25);
        chk("df_wrap_hs",     32'(df_if.hs), 0);
        chk("df_wrap_vs",     32'(df_if.vs), 3);
        chk("df_max_hs",      max_h,    799);
        chk("df_seq",         seq_bad,  0);
        chk("df_hsync_first", lo_first, 656);
        chk("df_hsync_last",  lo_last,  751);
        chk("df_hsync_count", lo_cnt,   3 * 96);
        chk("df_vsync_low",   vlo,      0);
        chk("df_de_count",    de_cnt,   3 * 640);
        chk("df_de_vs_blank", de_bad,   0);
        chk("df_sync_b",      sb_bad,   0);
        chk("df_line_starts", ls_cnt,   3);
        chk("df_frame_start", fs_cnt,   1);
    endtask

    initial begin
        rst_s          = 1'b1;
        rst_d          = 1'b1;
        sm_if.en       = 1'b1;
        sm_if.swap_req = 1'b0;
        df_if.en       = 1'b1;
        df_if.swap_req = 1'b0;
        repeat (3) @(posedge clk_25);
        #1 chk_on = 1'b1;
        @(posedge clk_25);
        #1;
        rst_s = 1'b0;
        rst_d = 1'b0;
        fork
            run_small();
            run_default();
        join
        repeat (2) @(negedge clk_25);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before t=500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/raster timing generator for the pipelined CPU's video output path. Successor to the fixed 640x480@60 controller.
- Timing, sync polarity and output pipeline delay are set by parameters. Adds a run enable, line/frame strobes, and a frame-buffer swap handshake aligned to vertical blanking.
- Sits between the 25 MHz pixel clock domain and the framebuffer read pipeline / DAC pins.

Parameters:
- CNT_W, 10, width of the hs/vs counters; must hold max(H_TOTAL, V_TOTAL)-1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (clocks).
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- HS_POL, 0, asserted level of vga_hsync (0 = active-low).
- VS_POL, 0, asserted level of vga_vsync.
- PIPE_DLY, 0, clocks of delay applied to sync/blank/de outputs (0..8).
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).

Ports:
- clk_25  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; 0 freezes the counters.
- swap_req  in  1  level request for a buffer swap at next vblank.
- hs  out  CNT_W  horizontal pixel counter (undelayed).
- vs  out  CNT_W  vertical line counter (undelayed).
- vga_hsync  out  1  horizontal sync, polarity HS_POL, delayed PIPE_DLY.
- vga_vsync  out  1  vertical sync, polarity VS_POL, delayed PIPE_DLY.
- sync_b  out  1  composite sync = vga_hsync & vga_vsync (post-delay).
- sync_blank  out  1  1 outside the active area, delayed PIPE_DLY.
- de  out  1  data enable = ~sync_blank.
- line_start  out  1  1-clock pulse when hs==0 (undelayed).
- frame_start  out  1  1-clock pulse when hs==0 and vs==0 (undelayed).
- swap_ack  out  1  1-clock swap acknowledge pulse.

Behaviour:
- Reset:
  - hs=0, vs=0, swap_ack=0.
  - Every delay stage loads inactive syncs (vga_hsync=~HS_POL, vga_vsync=~VS_POL), sync_blank=1, de=0.
  - On the clock after reset release, line_start=frame_start=1 if en=1.
  - Reset mid-frame aborts the frame with no partial pulses.
- Counting (en=1):
  - hs increments every clock. At hs==H_TOTAL-1, hs wraps to 0 and vs increments.
  - At vs==V_TOTAL-1 together with a line wrap, vs wraps to 0.
  - Counters never reach H_TOTAL or V_TOTAL.
- en=0:
  - hs and vs hold their values.
  - line_start, frame_start and swap_ack are forced to 0.
  - The delay pipe keeps shifting the frozen decode values.
- Decode (raw, from the current hs/vs):
  - h_sync_raw when H_ACTIVE+H_FP <= hs < H_ACTIVE+H_FP+H_SYNC.
  - v_sync_raw when V_ACTIVE+V_FP <= vs < V_ACTIVE+V_FP+V_SYNC.
  - active when hs<H_ACTIVE and vs<V_ACTIVE.
- Output delay:
  - PIPE_DLY=0: outputs are combinational from the counters.
  - PIPE_DLY=N>0: outputs are the raw decode registered through N flops, so they align with a pixel pipeline of latency N.
- Swap handshake:
  - vblank_edge = en & (hs==0) & (vs==V_ACTIVE).
  - swap_ack = swap_req & vblank_edge, registered so it asserts the clock after the edge cycle.
  - A swap_req rising during the edge cycle itself is accepted in that frame.
  - The requester must hold swap_req until it sees swap_ack, then drop it.
  - A swap_req still high after ack re-acks at the next frame's edge: one ack per frame maximum.
- Wrap + simultaneous events: at hs==0, vs==0, line_start and frame_start both pulse in the same cycle.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [15:0], reset 0.
  - Increments on each frame_start pulse and wraps 0xFFFF->0.
  - Adds output frame_odd = frame_cnt[0], for interlace/flip tests.
- Undefined: neither port exists and no counter logic is synthesised.

Test Plan:
- Defaults, en=1, run 2 frames -> hs wraps at 799, vs wraps at 524; vga_hsync low for exactly hs 656..751; vga_vsync low for vs 490..491; 420000 clocks per frame.
- Defaults -> sync_blank=0 and de=1 for exactly 640x480=307200 clocks per frame; sync_b=0 whenever either sync is low.
- H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP/V_SYNC/V_BP=1, HS_POL=1, PIPE_DLY=3 -> vga_hsync high exactly 3 clocks after hs==10 for 2 clocks; outputs are inactive/blank for the first 3 clocks after reset.
- Small config, en dropped at hs=5/vs=2 for 7 clocks -> hs/vs hold 5/2; no line_start; counting resumes at hs=6.
- Small config, swap_req raised at vs=1, held until ack -> single swap_ack the clock after hs==0,vs==4; req held through 2 frames -> exactly 2 acks.
- Small config, rst asserted at hs=9/vs=3 -> next clock hs=0, vs=0, sync_blank=1, swap_ack=0; with VGA_TIMING_FRAME_CNT_EN defined, frame_cnt=0 after reset and 3 after 3 complete frames.
